// File: rtl/aibndaux_crdet_por_seq.sv
// Partner-die presence sequencer: synchronizes and debounces crete_detect, runs a
// hold-off timer, then releases the partner POR; counts detect-loss link drops.
module aibndaux_crdet_por_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       crete_detect,
    input  logic       por_req,
    output logic       dn_por,
    output logic       link_ready,
    output logic       det_sync,
    output logic [2:0] state,
    output logic [7:0] lost_cnt
);

    localparam int MAX_CYC = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        HOLD     = 3'd2,
        ACTIVE   = 3'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 st_q;
    state_t                 st_nxt;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_nxt;
    logic [7:0]             lost_q;
    logic [7:0]             lost_nxt;
    logic                   dn_por_q;
    logic                   link_ready_q;

    // Only the last synchronizer stage is ever consumed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], crete_detect};
        end
    end

    assign det_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        st_nxt   = st_q;
        cnt_nxt  = cnt_q;
        lost_nxt = lost_q;
        if (por_req) begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (det_sync) begin
                        st_nxt  = DEBOUNCE;
                        cnt_nxt = '0;
                    end
                end
                DEBOUNCE: begin
                    if (!det_sync) begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        st_nxt  = HOLD;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!det_sync) begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        st_nxt  = ACTIVE;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt_q + CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (!det_sync) begin
                        st_nxt  = IDLE;
                        cnt_nxt = '0;
                        if (lost_q != 8'hFF) begin
                            lost_nxt = lost_q + 8'd1;
                        end
                    end
                end
                default: begin
                    st_nxt  = IDLE;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change only at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= IDLE;
            cnt_q        <= '0;
            lost_q       <= 8'd0;
            dn_por_q     <= 1'b1;
            link_ready_q <= 1'b0;
        end else begin
            st_q         <= st_nxt;
            cnt_q        <= cnt_nxt;
            lost_q       <= lost_nxt;
            dn_por_q     <= (st_nxt != ACTIVE);
            link_ready_q <= (st_nxt == ACTIVE);
        end
    end

    assign dn_por     = dn_por_q;
    assign link_ready = link_ready_q;
    assign state      = st_q;
    assign lost_cnt   = lost_q;

endmodule

// File: tb/tb_aibndaux_crdet_por_seq.sv
// Randomized scoreboard bench for aibndaux_crdet_por_seq: a run-length reference
// model predicts every cycle's outputs, a negedge monitor compares them.
module tb_aibndaux_crdet_por_seq;

    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int HOLD = 64;
    localparam int QUAL = 1 + DEB + HOLD;

    logic       clk;
    logic       rst;
    logic       crete_detect;
    logic       por_req;
    logic       dn_por;
    logic       link_ready;
    logic       det_sync;
    logic [2:0] state;
    logic [7:0] lost_cnt;

    // {dn_por, link_ready, det_sync, state, lost_cnt}
    logic [13:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: det_sync history, run length of qualifying edges, active flag
    bit hist[$];
    int run     = 0;
    bit active  = 0;
    int lost    = 0;

    aibndaux_crdet_por_seq #(
        .SYNC_STAGES(SYNC),
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .crete_detect(crete_detect),
        .por_req     (por_req),
        .dn_por      (dn_por),
        .link_ready  (link_ready),
        .det_sync    (det_sync),
        .state       (state),
        .lost_cnt    (lost_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_det();
        return hist[0];
    endfunction

    task automatic model_edge(input bit c, input bit p, input bit r);
        bit ds;
        int st;
        ds = model_det();
        if (r) begin
            run    = 0;
            active = 0;
            lost   = 0;
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        end else begin
            if (p) begin
                run    = 0;
                active = 0;
            end else if (!ds) begin
                if (active && lost < 255) lost++;
                run    = 0;
                active = 0;
            end else if (!active) begin
                run++;
                if (run == QUAL) active = 1;
            end
            void'(hist.pop_front());
            hist.push_back(c);
        end
        if (active) st = 3;
        else if (run == 0) st = 0;
        else if (run <= DEB) st = 1;
        else st = 2;
        exp_q.push_back({~active, active, model_det(), 3'(st), 8'(lost)});
    endtask

    task automatic step(input bit c, input bit p, input bit r);
        crete_detect = c;
        por_req      = p;
        rst          = r;
        @(posedge clk);
        model_edge(c, p, r);
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Monitor: every clock the DUT presents a full output vector
    initial begin
        logic [13:0] exp;
        logic [13:0] got;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {dn_por, link_ready, det_sync, state, lost_cnt};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d: got dn_por=%b link_ready=%b det_sync=%b state=%0d lost_cnt=%0d required dn_por=%b link_ready=%b det_sync=%b state=%0d lost_cnt=%0d",
                             cyc, got[13], got[12], got[11], got[10:8], got[7:0],
                             exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        rst          = 1'b1;
        crete_detect = 1'b1;
        por_req      = 1'b0;
        @(negedge clk);

        // Reset with detect already present
        repeat (3) step(1, 0, 1);

        // Clean attach: count edges until the link comes up
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step(1, 0, 0);
            n = i;
            if (link_ready) break;
        end
        check_val("attach_latency", n, SYNC + 1 + DEB + HOLD);
        check_val("attach_dn_por", int'(dn_por), 0);

        // Loss in ACTIVE
        repeat (6) step(0, 0, 0);
        check_val("loss_lost_cnt", int'(lost_cnt), 1);

        // Glitch reject: short detect pulse never reaches ACTIVE
        repeat (10) step(1, 0, 0);
        repeat (10) step(0, 0, 0);

        // One-cycle drop during HOLD, then full requalification
        repeat (50) step(1, 0, 0);
        step(0, 0, 0);
        repeat (100) step(1, 0, 0);

        // por_req together with detect loss in ACTIVE: no loss counted
        step(0, 1, 0);
        check_val("porreq_dn_por", int'(dn_por), 1);
        check_val("porreq_lost_cnt", int'(lost_cnt), 1);
        repeat (200) step(1, 1, 0);
        check_val("porreq_hold_state", int'(state), 0);
        repeat (90) step(1, 0, 0);

        // Reset from ACTIVE clears everything without counting a loss
        step(1, 0, 1);
        check_val("reset_active_lost", int'(lost_cnt), 0);
        repeat (85) step(1, 0, 0);

        // Repeated attach/loss until lost_cnt saturates
        for (int k = 0; k < 300; k++) begin
            int hi;
            int lo;
            hi = QUAL + SYNC + int'($urandom_range(1, 6));
            lo = int'($urandom_range(1, 4));
            repeat (hi) step(1, 0, 0);
            repeat (lo) step(0, 0, 0);
        end
        check_val("saturate_lost_cnt", int'(lost_cnt), 255);

        // Random detect/por_req traffic with mixed run lengths
        for (int k = 0; k < 60; k++) begin
            int len;
            bit c;
            bit p;
            len = int'($urandom_range(1, 100));
            c   = ($urandom_range(0, 3) != 0);
            p   = ($urandom_range(0, 9) == 0);
            repeat (len) step(c, p, 0);
        end

        repeat (4) @(negedge clk);
        check_val("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
